adder_arbiter: RTL
==================

# adder_arbiter

Shares one registered ADDER_WIDTH-bit adder among NUM_REQ requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants at most one requester per cycle and pushes the operands through a two-stage pipeline: operand register, then sum register. Each result is returned with the winning requester's index under a valid/ready output handshake with full backpressure.

## Interface
- ADDER_WIDTH, 96, operand width; the sum is ADDER_WIDTH+1 bits
- NUM_REQ, 4, number of requesters, 2..16
- ID_WIDTH, 2, index width; must equal ceil(log2(NUM_REQ))

- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  NUM_REQ  bit i: requester i has operands pending
- req_ready  output  NUM_REQ  one-hot or zero: grant to requester i this cycle
- req_a  input  NUM_REQ*ADDER_WIDTH  operand A, slice i belongs to requester i
- req_b  input  NUM_REQ*ADDER_WIDTH  operand B, same packing
- res_valid  output  1  res_sum/res_id hold a result
- res_ready  input  1  consumer accepts the result
- res_sum  output  ADDER_WIDTH+1  a+b, unsigned, carry in MSB
- res_id  output  ID_WIDTH  index of the requester that owns res_sum
- busy  output  1  stage-1 or stage-2 holds a valid entry

## Operation
- Stage 1 (s1) holds a_reg, b_reg, id and a valid flag. Stage 2 (s2) holds res_sum, res_id and res_valid.
- Transfers:
  - Accept: req_valid[i] & req_ready[i] at a posedge.
  - Output: res_valid & res_ready at a posedge.
- Stall rules:
  - s2 free: `adv2 = !res_valid | res_ready`.
  - s1 advances when `s1_valid & adv2`, and then loads res_sum = a_reg + b_reg.
  - s1 can load when `!s1_valid | adv2`.
- Grant is combinational from req_valid, the pointer/priority and the s1-can-load condition:
  - req_ready is all-zero when s1 cannot load or no req_valid is set.
  - req_ready[i] may depend on req_valid[i], so requesters must not make req_valid depend on req_ready.
- Round-robin pointer:
  - ID_WIDTH bits, reset 0.
  - Search order is ptr, ptr+1, …, wrapping at NUM_REQ-1 → 0.
  - On accept from requester g, ptr becomes g+1, wrapping to 0 when g = NUM_REQ-1. Otherwise ptr holds.
- A requester must hold req_valid and its operands stable until accepted. The arbiter never drops or duplicates a request.
- Addition is unsigned, no overflow: res_sum[ADDER_WIDTH] is the carry out. All-ones plus all-ones gives {1, all-ones<<1}.
- res_valid clears on output unless s1 advances in the same edge (back-to-back results).
- Reset values: s1_valid=0, res_valid=0, res_sum=0, res_id=0, a_reg=b_reg=0, ptr=0, busy=0, req_ready=0 during reset.
- Reset asserted mid-operation discards all in-flight entries with no result emitted. The first grant after reset deasserts goes to the lowest valid index at or after 0.

## Timing
- Latency: an accept at edge T gives res_valid=1 after edge T+1, provided s2 is free at T+1. Minimum is 2 cycles from grant cycle to result cycle.
- Throughput: one accept and one result per cycle when res_ready is held high.
- Backpressure:
  - With res_ready low and both stages full, req_ready is all-zero.
  - When res_ready rises, s2 outputs, s1 advances and a new accept happens, all at the same edge.
- Simultaneous output and s1 advance at the same edge: res_valid stays 1 and res_sum/res_id take the new values.
- Simultaneous reset and any handshake: reset wins, and nothing is accepted or emitted.

## Configuration
- ADDER_ARB_ROUND_ROBIN_EN:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority where the lowest asserted index always wins. The ptr register is removed, and the latency and handshake rules are unchanged.

## Test plan
- Single request: after reset, req_valid=0001, a=5, b=7, res_ready=1.
  - req_ready=0001 in the same cycle.
  - Two cycles later res_valid=1, res_sum=12, res_id=0 for exactly one cycle.
- Carry boundary: requester 2 sends a=b=2^96-1.
  - res_sum = 2^97-2, res_id=2.
  - Also a=2^96-1, b=1 gives res_sum = 2^96.
- Round-robin fairness: req_valid=1111 held for 8 cycles, res_ready=1.
  - Grant order 0,1,2,3,0,1,2,3; res_id follows the same order, one result per cycle.
  - With the macro undefined, all 8 grants go to requester 0.
- Backpressure: continuous requests with res_ready=0 for 5 cycles.
  - Exactly 2 accepts, then req_ready=0000 and res_sum held stable.
  - When res_ready=1, results arrive in accept order with none lost or duplicated.
- Reset mid-flight: assert reset for 1 cycle while both stages are full.
  - Next cycle res_valid=0, busy=0, res_sum=0.
  - The next accept with req_valid=0110 goes to requester 1.
- Randomized check: random req_valid/res_ready over 10k cycles against a scoreboard.
  - Every accepted (id, a+b) appears exactly once, in order.
  - req_ready is always one-hot or zero.

Source files
------------

// File: rtl/adder_arbiter.sv
// Shares one registered adder among NUM_REQ valid/ready requesters: operand stage, then sum stage.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest requesting index always wins.
module adder_arbiter #(
    parameter int ADDER_WIDTH = 96,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ADDER_WIDTH:0]           res_sum,
    output logic [ID_WIDTH-1:0]            res_id,
    output logic                           busy
);

    logic                   s1_valid_q, s1_valid_d;
    logic [ADDER_WIDTH-1:0] a_q, a_d;
    logic [ADDER_WIDTH-1:0] b_q, b_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic                   res_valid_q, res_valid_d;
    logic [ADDER_WIDTH:0]   res_sum_q, res_sum_d;
    logic [ID_WIDTH-1:0]    res_id_q, res_id_d;

    logic                   adv2;
    logic                   s1_adv;
    logic                   s1_can_load;
    logic                   found;
    logic                   accept;
    logic [ID_WIDTH-1:0]    gnt_id;
    logic [ADDER_WIDTH-1:0] a_sel;
    logic [ADDER_WIDTH-1:0] b_sel;

    assign adv2        = !res_valid_q || res_ready;
    assign s1_adv      = s1_valid_q && adv2;
    assign s1_can_load = !s1_valid_q || adv2;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  req_rot;
    logic [ID_WIDTH:0]   idx_sum;

    // Rotate the request vector so bit k is requester ptr+k, then map the winner back.
    always_comb begin
        found   = 1'b0;
        gnt_id  = '0;
        idx_sum = '0;
        req_rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                idx_sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
                if (idx_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                    idx_sum = idx_sum - (ID_WIDTH+1)'(NUM_REQ);
                end
                gnt_id = idx_sum[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k]) begin
                found  = 1'b1;
                gnt_id = ID_WIDTH'(k);
            end
        end
    end
`endif

    assign accept = found && s1_can_load && !reset;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_WIDTH'(i)) begin
                req_ready[i] = accept;
                a_sel        = req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
                b_sel        = req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
            end
        end
    end

    // Operand stage: a new accept may overwrite an entry that is leaving this edge.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = a_sel;
            b_d        = b_sel;
            id_d       = gnt_id;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        if (s1_adv) begin
            res_valid_d = 1'b1;
            res_sum_d   = {1'b0, a_q} + {1'b0, b_q};
            res_id_d    = id_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign busy      = s1_valid_q || res_valid_q;

endmodule
